// File: rtl/idct_pkg.sv
// Shared constants for the IDCT pipeline: default stage offsets, address width,
// block size and sequencer state encoding.
package idct_pkg;

  localparam int TP1_START_DEF = 25;
  localparam int TP2_START_DEF = 34;
  localparam int OUT_START_DEF = 43;
  localparam int AW_DEF        = 15;

  localparam int BLK      = 8;
  localparam int BLK_BITS = $clog2(BLK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } idct_seq_state_e;

  // A job length is usable only when it covers whole 8-row blocks.
  function automatic logic blk_aligned(input logic [BLK_BITS-1:0] lsb);
    return (lsb == {BLK_BITS{1'b0}});
  endfunction

endpackage

// File: rtl/idct_seq_ctrl_if.sv
// Job request / pipeline control bundle of the IDCT sequencer.
// Build option IDCT_SEQ_ERR_EN adds the sticky err flag.
interface idct_seq_ctrl_if #(
  parameter int AW = 15
);
  logic          start;
  logic [AW-1:0] num_rows;
  logic          abort;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          tp1_en;
  logic          tp1_rst_n;
  logic          tp2_en;
  logic          tp2_rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;
`ifdef IDCT_SEQ_ERR_EN
  logic          err;

  modport master (
    output start, num_rows, abort,
    input  rd_en, rd_addr, tp1_en, tp1_rst_n, tp2_en, tp2_rst_n,
    input  wr_en, wr_addr, busy, done, err
  );
  modport slave (
    input  start, num_rows, abort,
    output rd_en, rd_addr, tp1_en, tp1_rst_n, tp2_en, tp2_rst_n,
    output wr_en, wr_addr, busy, done, err
  );
`else
  modport master (
    output start, num_rows, abort,
    input  rd_en, rd_addr, tp1_en, tp1_rst_n, tp2_en, tp2_rst_n,
    input  wr_en, wr_addr, busy, done
  );
  modport slave (
    input  start, num_rows, abort,
    output rd_en, rd_addr, tp1_en, tp1_rst_n, tp2_en, tp2_rst_n,
    output wr_en, wr_addr, busy, done
  );
`endif
endinterface

// File: rtl/idct_seq_window.sv
// Registered [lo, hi) window decode of the job counter, with the
// window-relative offset of the counter as a second registered output.
module idct_seq_window #(
  parameter int TW = 16,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [TW-1:0] t,
  input  logic [TW-1:0] lo,
  input  logic [TW-1:0] hi,
  output logic          hit_r,
  output logic [AW-1:0] offs_r
);
  logic in_s;

  // Window membership of the next counter value
  always_comb begin
    in_s = en && (t >= lo) && (t < hi);
  end

  // Hit flag and offset, both forced to zero outside the window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_r  <= 1'b0;
      offs_r <= {AW{1'b0}};
    end else if (in_s) begin
      hit_r  <= 1'b1;
      offs_r <= AW'(t - lo);
    end else begin
      hit_r  <= 1'b0;
      offs_r <= {AW{1'b0}};
    end
  end
endmodule

// File: rtl/idct_seq_ctrl.sv
// Job-level sequencer for the two-pass IDCT pipeline (read, transpose 1/2, write).
// Build option IDCT_SEQ_ERR_EN adds a sticky flag for rejected job lengths.
module idct_seq_ctrl
  import idct_pkg::*;
#(
  parameter int TP1_START = TP1_START_DEF,
  parameter int TP2_START = TP2_START_DEF,
  parameter int OUT_START = OUT_START_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  idct_seq_ctrl_if.slave bus
);
  // One extra counter bit so OUT_START + N never wraps.
  localparam int            TW     = AW + 1;
  localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_TOP  = {TW{1'b1}};
  localparam logic [TW-1:0] TP1_LO = TW'(TP1_START);
  localparam logic [TW-1:0] TP2_LO = TW'(TP2_START);
  localparam logic [TW-1:0] OUT_LO = TW'(OUT_START);
  localparam logic [1:0]    S_IDLE = ST_IDLE;
  localparam logic [1:0]    S_RUN  = ST_RUN;
  localparam logic [1:0]    S_FIN  = ST_FIN;

  logic [1:0]    state_r, state_nx_s;
  logic [TW-1:0] t_r, t_nx_s, t_inc_s, end_s, rd_hi_s, wr_hi_s;
  logic [AW-1:0] n_r, n_nx_s;
  logic          legal_s, run_nx_s;
  logic          busy_r, done_r;
  logic          rd_en_s, tp1_en_s, tp2_en_s, wr_en_s;
  logic [AW-1:0] rd_addr_s, wr_addr_s, tp1_offs_unused_s, tp2_offs_unused_s;

  // Next state, counter and latched length
  always_comb begin
    legal_s    = (bus.num_rows != {AW{1'b0}}) && blk_aligned(bus.num_rows[BLK_BITS-1:0]);
    end_s      = OUT_LO + {1'b0, n_r};
    t_inc_s    = t_r + T_ONE;
    state_nx_s = state_r;
    t_nx_s     = t_r;
    n_nx_s     = n_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start && legal_s) begin
          state_nx_s = S_RUN;
          t_nx_s     = T_ZERO;
          n_nx_s     = bus.num_rows;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_nx_s = S_IDLE;
          t_nx_s     = T_ZERO;
        end else if (t_inc_s == end_s) begin
          state_nx_s = S_FIN;
          t_nx_s     = T_ZERO;
        end else begin
          t_nx_s     = t_inc_s;
        end
      end
      S_FIN: begin
        state_nx_s = S_IDLE;
        t_nx_s     = T_ZERO;
      end
      default: begin
        state_nx_s = S_IDLE;
        t_nx_s     = T_ZERO;
      end
    endcase
    // Windows see the length being latched on the accepting edge.
    run_nx_s = (state_nx_s == S_RUN);
    rd_hi_s  = {1'b0, n_nx_s};
    wr_hi_s  = OUT_LO + rd_hi_s;
  end

  // FSM state, job counter and job length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      t_r     <= T_ZERO;
      n_r     <= {AW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      t_r     <= t_nx_s;
      n_r     <= n_nx_s;
    end
  end

  // Job status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != S_IDLE);
      done_r <= (state_nx_s == S_FIN);
    end
  end

  idct_seq_window #(.TW(TW), .AW(AW)) u_rd_win (
    .clk(clk), .reset(reset), .en(run_nx_s), .t(t_nx_s),
    .lo(T_ZERO), .hi(rd_hi_s), .hit_r(rd_en_s), .offs_r(rd_addr_s)
  );
  idct_seq_window #(.TW(TW), .AW(AW)) u_tp1_win (
    .clk(clk), .reset(reset), .en(run_nx_s), .t(t_nx_s),
    .lo(TP1_LO), .hi(T_TOP), .hit_r(tp1_en_s), .offs_r(tp1_offs_unused_s)
  );
  idct_seq_window #(.TW(TW), .AW(AW)) u_tp2_win (
    .clk(clk), .reset(reset), .en(run_nx_s), .t(t_nx_s),
    .lo(TP2_LO), .hi(T_TOP), .hit_r(tp2_en_s), .offs_r(tp2_offs_unused_s)
  );
  idct_seq_window #(.TW(TW), .AW(AW)) u_wr_win (
    .clk(clk), .reset(reset), .en(run_nx_s), .t(t_nx_s),
    .lo(OUT_LO), .hi(wr_hi_s), .hit_r(wr_en_s), .offs_r(wr_addr_s)
  );

`ifdef IDCT_SEQ_ERR_EN
  logic err_r;

  // Sticky rejected-length flag, cleared by the next accepted job
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if ((state_r == S_IDLE) && bus.start) begin
      err_r <= !legal_s;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`endif

  assign bus.rd_en     = rd_en_s;
  assign bus.rd_addr   = rd_addr_s;
  assign bus.tp1_en    = tp1_en_s;
  assign bus.tp1_rst_n = tp1_en_s;
  assign bus.tp2_en    = tp2_en_s;
  assign bus.tp2_rst_n = tp2_en_s;
  assign bus.wr_en     = wr_en_s;
  assign bus.wr_addr   = wr_addr_s;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_idct_seq_ctrl.sv
// Self-checking bench for idct_seq_ctrl: job-phase model compared every cycle
// plus directed literal checks. Honours IDCT_SEQ_ERR_EN.
module tb_idct_seq_ctrl;
  import idct_pkg::*;

  localparam int AW = AW_DEF;
  localparam int T1 = TP1_START_DEF;
  localparam int T2 = TP2_START_DEF;
  localparam int OS = OUT_START_DEF;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  idct_seq_ctrl_if #(.AW(AW)) bus ();

  idct_seq_ctrl #(.TP1_START(T1), .TP2_START(T2), .OUT_START(OS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: ph = -1 when idle, else cycles since the job's first read.
  int ph   = -1;
  int mn   = 0;
  bit merr = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph   = -1;
      merr = 1'b0;
    end else if (ph < 0) begin
      if (bus.start === 1'b1) begin
        if (int'(bus.num_rows) != 0 && int'(bus.num_rows) % 8 == 0) begin
          ph   = 0;
          mn   = int'(bus.num_rows);
          merr = 1'b0;
        end else begin
          merr = 1'b1;
        end
      end
    end else if (bus.abort === 1'b1) begin
      ph = -1;
    end else if (ph == OS + mn) begin
      ph = -1;
    end else begin
      ph = ph + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic          e_rd, e_t1, e_t2, e_wr, e_busy, e_done, e_err, a_err;
    logic [AW-1:0] e_ra, e_wa;
    logic [38:0]   exp_v, act_v;
    e_busy = (ph >= 0);
    e_done = (ph >= 0) && (ph == OS + mn);
    e_rd   = (ph >= 0) && (ph < mn);
    e_t1   = (ph >= T1) && (ph < OS + mn);
    e_t2   = (ph >= T2) && (ph < OS + mn);
    e_wr   = (ph >= OS) && (ph < OS + mn);
    e_ra   = e_rd ? AW'(ph) : {AW{1'b0}};
    e_wa   = e_wr ? AW'(ph - OS) : {AW{1'b0}};
`ifdef IDCT_SEQ_ERR_EN
    e_err  = merr;
    a_err  = bus.err;
`else
    e_err  = 1'b0;
    a_err  = 1'b0;
`endif
    exp_v = {e_busy, e_done, e_rd, e_ra, e_t1, e_t1, e_t2, e_t2, e_wr, e_wa, e_err};
    act_v = {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.tp1_en, bus.tp1_rst_n,
             bus.tp2_en, bus.tp2_rst_n, bus.wr_en, bus.wr_addr, a_err};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_cmp @%0t ph=%0d act=%h exp=%h", $time, ph, act_v, exp_v);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Request a job for one edge; returns in the cycle holding t=0
  task automatic launch(input int n);
    bus.num_rows = AW'(n);
    bus.start    = 1'b1;
    step(1);
    bus.start    = 1'b0;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.num_rows = {AW{1'b0}};
    reset        = 1'b0;
    step(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tp1_rst_n", bus.tp1_rst_n, 0);
    reset = 1'b1;
    step(1);

    // Nominal job, N=8
    launch(8);
    chk("nom_rd_t0", {bus.rd_en, 15'(bus.rd_addr)}, 32'h0000_8000);
    chk("nom_busy_t0", bus.busy, 1);
    step(7);
    chk("nom_rd_addr_t7", bus.rd_addr, 7);
    step(1);
    chk("nom_rd_en_t8", bus.rd_en, 0);
    step(16);
    chk("nom_tp1_t24", bus.tp1_en, 0);
    step(1);
    chk("nom_tp1_t25", {bus.tp1_en, bus.tp1_rst_n}, 3);
    step(8);
    chk("nom_tp2_t33", bus.tp2_en, 0);
    step(1);
    chk("nom_tp2_t34", {bus.tp2_en, bus.tp2_rst_n}, 3);
    step(9);
    chk("nom_wr_t43", {bus.wr_en, 15'(bus.wr_addr)}, 32'h0000_8000);
    step(7);
    chk("nom_wr_t50", {bus.wr_en, 15'(bus.wr_addr)}, 32'h0000_8007);
    step(1);
    chk("nom_done_t51", {bus.done, bus.busy, bus.tp1_rst_n, bus.wr_en}, 4'b1100);
    step(1);
    chk("nom_idle_t52", {bus.done, bus.busy}, 0);

    // Illegal lengths, then a legal start
    launch(12);
    chk("ill12_busy", bus.busy, 0);
`ifdef IDCT_SEQ_ERR_EN
    chk("ill12_err", bus.err, 1);
`endif
    launch(0);
    chk("ill0_busy", {bus.busy, bus.rd_en}, 0);
    launch(8);
    chk("legal_after_ill_busy", bus.busy, 1);
`ifdef IDCT_SEQ_ERR_EN
    chk("legal_clears_err", bus.err, 0);
`endif
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    chk("abort_t1_busy", bus.busy, 0);

    // Abort at t=30 with a mid-job length change, then immediate restart
    launch(16);
    bus.num_rows = AW'(5);
    step(30);
    chk("abt_pre_tp1", bus.tp1_en, 1);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    chk("abt_outputs", {bus.busy, bus.done, bus.tp1_rst_n, bus.tp1_en, bus.rd_en}, 0);
    launch(8);
    chk("abt_restart_t0", {bus.busy, bus.rd_en, 15'(bus.rd_addr)}, 32'h0001_8000);
    step(51);
    chk("abt_restart_done", bus.done, 1);
    step(1);

    // Abort asserted in IDLE is ignored; abort in FIN suppresses nothing extra
    bus.abort = 1'b1;
    launch(8);
    bus.abort = 1'b0;
    chk("idle_abort_ignored", bus.busy, 1);
    step(51);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    chk("fin_abort_idle", {bus.busy, bus.done}, 0);

    // Back-to-back: start held high
    bus.num_rows = AW'(8);
    bus.start    = 1'b1;
    step(1);
    chk("b2b_j1_t0", bus.rd_en, 1);
    step(51);
    chk("b2b_j1_done", bus.done, 1);
    step(1);
    chk("b2b_gap_idle", bus.busy, 0);
    step(1);
    chk("b2b_j2_t0", {bus.busy, bus.rd_en, 15'(bus.rd_addr)}, 32'h0001_8000);
    step(25);
    bus.start = 1'b0;
    chk("b2b_j2_tp1", bus.tp1_en, 1);
    step(26);
    chk("b2b_j2_done", bus.done, 1);
    step(1);

    // Maximum length
    launch(32760);
    step(32759);
    chk("max_rd_last", {bus.rd_en, 15'(bus.rd_addr)}, 32'h0000_8000 + 32759);
    step(43);
    chk("max_wr_last", {bus.wr_en, 15'(bus.wr_addr)}, 32'h0000_8000 + 32759);
    step(1);
    chk("max_done", {bus.done, bus.wr_en}, 2'b10);
    step(1);
    chk("max_idle", bus.busy, 0);

    // Asynchronous reset mid-job
    launch(8);
    step(40);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_outputs", {bus.busy, bus.rd_en, bus.tp1_en, bus.tp1_rst_n,
                           bus.tp2_en, bus.tp2_rst_n, bus.wr_en, bus.done}, 0);
    step(2);
    reset = 1'b1;
    step(1);
    launch(8);
    chk("areset_restart_t0", {bus.busy, bus.rd_en, 15'(bus.rd_addr)}, 32'h0001_8000);
    step(51);
    chk("areset_restart_done", bus.done, 1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
